// File: rtl/machine_d.sv
// Moore detector for the overlapping serial pattern 1-0-1-1 on x.
// F is decoded from the registered state only, so x never reaches F combinationally.
module machine_d (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic F
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S0;
    F       = 1'b0;
    case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S1 : S2;
      S2: state_d = x ? S3 : S0;
      S3: state_d = x ? S4 : S2;
      S4: begin
        F       = 1'b1;
        // the trailing 1 restarts a match, so a detect can overlap the next one
        state_d = x ? S1 : S2;
      end
      // unused encodings 101/110/111 recover to S0 with F low
      default: state_d = S0;
    endcase
  end

endmodule

// File: tb/tb_machine_d.sv
// Self-checking bench for machine_d: directed sequences plus a random stream,
// compared against a model built from the last four bits received since reset.
module tb_machine_d;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x   = 1'b0;
  logic F;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pulses   = 0;

  logic [3:0]  hist  = '0;
  int unsigned nbits = 0;

  machine_d dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .F   (F)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, optionally glitch rst and x
  // between edges, then compare F 1 ns after the rising edge.
  task automatic step(input logic xi, input logic ri, input logic glitch, input string tag);
    logic exp_f;
    @(negedge clk);
    rst = ri;
    x   = xi;
    if (glitch && !ri) begin
      #1 rst = 1'b1; x = ~xi;
      #3 rst = 1'b0; x = xi;
    end
    @(posedge clk);
    if (ri) begin
      hist  = '0;
      nbits = 0;
    end else begin
      hist = {hist[2:0], xi};
      if (nbits < 4) nbits++;
    end
    exp_f = (nbits >= 4) && (hist == 4'b1011);
    #1;
    check(tag, {31'd0, F}, {31'd0, exp_f});
    if (F === 1'b1) pulses++;
  endtask

  task automatic do_reset(input int unsigned edges);
    for (int unsigned i = 0; i < edges; i++) step(i[0], 1'b1, 1'b0, "reset");
  endtask

  logic [22:0] stream;
  logic [6:0]  seq_ov;
  logic [5:0]  seq_nm;

  initial begin
    stream = 23'b11110111110000101010001;
    seq_ov = 7'b1011011;
    seq_nm = 6'b101011;

    // reset held for two edges with x toggling
    do_reset(2);

    // basic detect, then a 0 leaves the detector in the "10" state
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, "basic_b1");
    step(1'b0, 1'b0, 1'b0, "basic_b2");
    step(1'b1, 1'b0, 1'b0, "basic_b3");
    step(1'b1, 1'b0, 1'b0, "basic_b4");
    step(1'b0, 1'b0, 1'b0, "basic_tail");
    check("basic_pulses", pulses, 32'd1);

    // overlap 1011011: pulses after the 4th and 7th bits
    do_reset(1);
    pulses = 0;
    for (int i = 6; i >= 0; i--) step(seq_ov[i], 1'b0, 1'b0, "overlap");
    step(1'b0, 1'b0, 1'b0, "overlap_tail");
    check("overlap_pulses", pulses, 32'd2);

    // near miss 101011: single pulse at the 6th bit
    do_reset(1);
    pulses = 0;
    for (int i = 5; i >= 0; i--) step(seq_nm[i], 1'b0, 1'b0, "near_miss");
    check("near_miss_pulses", pulses, 32'd1);

    // 23-bit stream LSB first, then zeros
    do_reset(1);
    pulses = 0;
    for (int i = 0; i < 23; i++) step(stream[i], 1'b0, 1'b0, "stream");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "stream_zeros");
    check("stream_pulses", pulses, 32'd1);

    // mid-stream reset discards the partial 101
    do_reset(1);
    pulses = 0;
    step(1'b1, 1'b0, 1'b0, "midrst_b1");
    step(1'b0, 1'b0, 1'b0, "midrst_b2");
    step(1'b1, 1'b0, 1'b0, "midrst_b3");
    step(1'b0, 1'b1, 1'b0, "midrst_rst");
    step(1'b1, 1'b0, 1'b0, "midrst_b4");
    check("midrst_pulses", pulses, 32'd0);

    // reset and x glitches that span no rising edge must not disturb a match
    do_reset(1);
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, "glitch_b1");
    step(1'b0, 1'b0, 1'b1, "glitch_b2");
    step(1'b1, 1'b0, 1'b1, "glitch_b3");
    step(1'b1, 1'b0, 1'b1, "glitch_b4");
    check("glitch_pulses", pulses, 32'd1);

    // random stream with occasional resets and between-edge glitches
    for (int unsigned i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0),
           "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
